// File: rtl/uart_tx_frame_pkg.sv
// Shared types and helpers for the UART transmit frame engine.
// Parity is computed over a zero-extended word, so one helper serves every DATA_BITS setting.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int MAX_DATA_BITS = 9;

  // Zero padding leaves the XOR reduction unchanged, so narrower words extend safely.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                       input logic                     odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Host-side word handshake for uart_tx_frame, carrying per-frame format controls.
// Parity controls exist only when UART_TX_PARITY_EN is defined.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);

  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] tx_data;
  logic                 two_stop;
`ifdef UART_TX_PARITY_EN
  logic                 parity_en;
  logic                 even_odd;

  modport master (
    output tx_valid,
    output tx_data,
    output two_stop,
    output parity_en,
    output even_odd,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    input  two_stop,
    input  parity_en,
    input  even_odd,
    output tx_ready
  );
`else
  modport master (
    output tx_valid,
    output tx_data,
    output two_stop,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    input  two_stop,
    output tx_ready
  );
`endif

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: one-cycle tick every CLK_DIV cycles, restarted by a synchronous clear.
module uart_baud_tick #(
  parameter int CLK_DIV = 434
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count_reg + 1'b1;
    if (clear || (count_reg == LAST_COUNT)) begin
      count_next = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // The final cycle of each period; suppressed while held in clear.
  assign tick = !clear && (count_reg == LAST_COUNT);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit frame engine: start, LSB-first data, optional parity, 1 or 2 stop bits.
// Optional parity support is built only when UART_TX_PARITY_EN is defined.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int CLK_DIV   = 434
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  uart_tx_frame_if.slave  tx_if,
  output logic            busy,
  output logic            serial_out
);

  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  tx_state_t            state_reg;
  tx_state_t            state_next;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;
  logic [BCW-1:0]       bit_cnt_reg;
  logic [BCW-1:0]       bit_cnt_next;
  logic                 stop_cnt_reg;
  logic                 stop_cnt_next;
  logic                 two_stop_reg;
  logic                 serial_out_reg;
  logic                 serial_next;
  logic                 accept;
  logic                 tick;
  logic                 parity_sel;

  assign accept = tx_if.tx_valid && (state_reg == IDLE);

  uart_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_tick (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .clear   (state_reg == IDLE),
    .tick    (tick)
  );

`ifdef UART_TX_PARITY_EN
  logic                     parity_en_reg;
  logic                     parity_bit_reg;
  logic [MAX_DATA_BITS-1:0] data_ext;

  always_comb begin
    data_ext                = '0;
    data_ext[DATA_BITS-1:0] = tx_if.tx_data;
  end

  // Parity is fixed at acceptance so later input changes cannot corrupt the frame.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_en_reg  <= 1'b0;
      parity_bit_reg <= 1'b0;
    end else if (accept) begin
      parity_en_reg  <= tx_if.parity_en;
      parity_bit_reg <= calc_parity(data_ext, tx_if.even_odd == PARITY_ODD);
    end
  end

  assign parity_sel = parity_en_reg;
`else
  assign parity_sel = 1'b0;
`endif

  // State register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Frame datapath and line flop
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      stop_cnt_reg   <= 1'b0;
      two_stop_reg   <= 1'b0;
      serial_out_reg <= 1'b1;
    end else begin
      shift_reg      <= shift_next;
      bit_cnt_reg    <= bit_cnt_next;
      stop_cnt_reg   <= stop_cnt_next;
      serial_out_reg <= serial_next;
      if (accept) begin
        two_stop_reg <= tx_if.two_stop;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next    = START;
          shift_next    = tx_if.tx_data;
          bit_cnt_next  = '0;
          stop_cnt_next = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_reg == LAST_BIT) begin
            state_next = parity_sel ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
            shift_next   = shift_reg >> 1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (two_stop_reg && !stop_cnt_reg) begin
            stop_cnt_next = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line value for the coming cycle, registered so the pad never sees a glitch.
  always_comb begin
    serial_next = 1'b1;
    case (state_next)
      IDLE:   serial_next = 1'b1;
      START:  serial_next = 1'b0;
      DATA:   serial_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY: serial_next = parity_bit_reg;
`else
      PARITY: serial_next = 1'b1;
`endif
      STOP:   serial_next = 1'b1;
      default: serial_next = 1'b1;
    endcase
  end

  assign serial_out     = serial_out_reg;
  assign busy           = (state_reg != IDLE);
  assign tx_if.tx_ready = (state_reg == IDLE);

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: an 8-bit/CLK_DIV=4 engine and a 5-bit/CLK_DIV=2 engine.
module tb_uart_tx_frame;
  import uart_pkg::*;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic busy8, ser8, busy5, ser5;

  int total = 0;
  int bad   = 0;

  logic cap_line  [0:127];
  logic cap_busy  [0:127];
  logic cap_ready [0:127];

  always #5 sys_clk = ~sys_clk;

  uart_tx_frame_if #(.DATA_BITS(8)) if8 ();
  uart_tx_frame_if #(.DATA_BITS(5)) if5 ();

  uart_tx_frame #(.DATA_BITS(8), .CLK_DIV(4)) dut8 (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .tx_if      (if8),
    .busy       (busy8),
    .serial_out (ser8)
  );

  uart_tx_frame #(.DATA_BITS(5), .CLK_DIV(2)) dut5 (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .tx_if      (if5),
    .busy       (busy5),
    .serial_out (ser5)
  );

  // Offer one word on the 8-bit engine, then scramble the inputs right after acceptance.
  task automatic send8(input logic [7:0] d, input logic ts, input logic pe, input logic eo);
    @(negedge sys_clk);
    if8.tx_valid = 1'b1;
    if8.tx_data  = d;
    if8.two_stop = ts;
`ifdef UART_TX_PARITY_EN
    if8.parity_en = pe;
    if8.even_odd  = eo;
`endif
    @(posedge sys_clk);
    #1;
    if8.tx_valid = 1'b0;
    if8.tx_data  = ~d;
    if8.two_stop = ~ts;
`ifdef UART_TX_PARITY_EN
    if8.parity_en = ~pe;
    if8.even_odd  = ~eo;
`endif
  endtask

  task automatic capture8(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      cap_line[i]  = ser8;
      cap_busy[i]  = busy8;
      cap_ready[i] = if8.tx_ready;
    end
  endtask

  task automatic test_reset;
    #12;
    total++;
    if (ser8 !== 1'b1) begin bad++; $display("FAIL reset_serial got=%b want=1", ser8); end
    total++;
    if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy8); end
    total++;
    if (if8.tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", if8.tx_ready); end
    total++;
    if (ser5 !== 1'b1) begin bad++; $display("FAIL reset_serial5 got=%b want=1", ser5); end
    @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    total++;
    if (busy8 !== 1'b0 || ser8 !== 1'b1) begin
      bad++; $display("FAIL idle_after_reset busy=%b ser=%b want busy=0 ser=1", busy8, ser8);
    end
  endtask

  task automatic test_basic;
    logic [9:0] exp;
    exp = 10'b1010101010;  // 0x55, one stop
    send8(8'h55, 1'b0, 1'b0, PARITY_EVEN);
    capture8(41);
    for (int i = 0; i < 40; i++) begin
      total++;
      if (cap_line[i] !== exp[i/4]) begin
        bad++; $display("FAIL basic_line cyc=%0d got=%b want=%b", i, cap_line[i], exp[i/4]);
      end
      total++;
      if (cap_busy[i] !== 1'b1 || cap_ready[i] !== 1'b0) begin
        bad++; $display("FAIL basic_busy cyc=%0d busy=%b ready=%b want busy=1 ready=0", i, cap_busy[i], cap_ready[i]);
      end
    end
    total++;
    if (cap_busy[40] !== 1'b0 || cap_ready[40] !== 1'b1 || cap_line[40] !== 1'b1) begin
      bad++; $display("FAIL basic_end busy=%b ready=%b ser=%b want 0 1 1", cap_busy[40], cap_ready[40], cap_line[40]);
    end
  endtask

  task automatic test_two_stop;
    logic [10:0] exp;
    exp = 11'b11111111110;  // 0xFF, two stop bits
    send8(8'hFF, 1'b1, 1'b0, PARITY_EVEN);
    capture8(45);
    for (int i = 0; i < 44; i++) begin
      total++;
      if (cap_line[i] !== exp[i/4] || cap_busy[i] !== 1'b1) begin
        bad++; $display("FAIL two_stop cyc=%0d ser=%b busy=%b want ser=%b busy=1", i, cap_line[i], cap_busy[i], exp[i/4]);
      end
    end
    total++;
    if (cap_busy[44] !== 1'b0 || cap_ready[44] !== 1'b1) begin
      bad++; $display("FAIL two_stop_end busy=%b ready=%b want 0 1", cap_busy[44], cap_ready[44]);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    logic [10:0] exp_even;
    logic [10:0] exp_odd;
    exp_even = 11'b10101000110;  // 0xA3, parity 0
    exp_odd  = 11'b11101000110;  // 0xA3, parity 1
    send8(8'hA3, 1'b0, 1'b1, PARITY_EVEN);
    capture8(45);
    for (int i = 0; i < 44; i++) begin
      total++;
      if (cap_line[i] !== exp_even[i/4] || cap_busy[i] !== 1'b1) begin
        bad++; $display("FAIL parity_even cyc=%0d ser=%b busy=%b want ser=%b busy=1", i, cap_line[i], cap_busy[i], exp_even[i/4]);
      end
    end
    total++;
    if (cap_busy[44] !== 1'b0) begin bad++; $display("FAIL parity_even_end busy=%b want 0", cap_busy[44]); end
    send8(8'hA3, 1'b0, 1'b1, PARITY_ODD);
    capture8(45);
    for (int i = 0; i < 44; i++) begin
      total++;
      if (cap_line[i] !== exp_odd[i/4] || cap_busy[i] !== 1'b1) begin
        bad++; $display("FAIL parity_odd cyc=%0d ser=%b busy=%b want ser=%b busy=1", i, cap_line[i], cap_busy[i], exp_odd[i/4]);
      end
    end
    total++;
    if (cap_busy[44] !== 1'b0) begin bad++; $display("FAIL parity_odd_end busy=%b want 0", cap_busy[44]); end
  endtask
`endif

  task automatic test_back_to_back;
    logic [9:0] exp1;
    logic [9:0] exp2;
    logic       want;
    exp1 = 10'b1000000010;  // 0x01
    exp2 = 10'b1100000000;  // 0x80
    @(negedge sys_clk);
    if8.tx_valid = 1'b1;
    if8.tx_data  = 8'h01;
    if8.two_stop = 1'b0;
`ifdef UART_TX_PARITY_EN
    if8.parity_en = 1'b0;
`endif
    @(posedge sys_clk);
    #1;
    if8.tx_data = 8'h80;
    for (int i = 0; i < 82; i++) begin
      @(negedge sys_clk);
      cap_line[i]  = ser8;
      cap_busy[i]  = busy8;
      cap_ready[i] = if8.tx_ready;
      if (i == 41) if8.tx_valid = 1'b0;
    end
    for (int i = 0; i < 82; i++) begin
      if (i < 40)       want = exp1[i/4];
      else if (i == 40) want = 1'b1;
      else if (i < 81)  want = exp2[(i-41)/4];
      else              want = 1'b1;
      total++;
      if (cap_line[i] !== want) begin
        bad++; $display("FAIL b2b_line cyc=%0d got=%b want=%b", i, cap_line[i], want);
      end
    end
    total++;
    if (cap_ready[40] !== 1'b1 || cap_busy[40] !== 1'b0) begin
      bad++; $display("FAIL b2b_gap ready=%b busy=%b want 1 0", cap_ready[40], cap_busy[40]);
    end
    total++;
    if (cap_ready[41] !== 1'b0 || cap_busy[41] !== 1'b1) begin
      bad++; $display("FAIL b2b_second_start ready=%b busy=%b want 0 1", cap_ready[41], cap_busy[41]);
    end
    total++;
    if (cap_busy[81] !== 1'b0) begin bad++; $display("FAIL b2b_end busy=%b want 0", cap_busy[81]); end
  endtask

  task automatic test_reset_mid_frame;
    logic [9:0] exp;
    exp = 10'b1001111000;  // 0x3C
    send8(8'hAA, 1'b0, 1'b0, PARITY_EVEN);
    capture8(18);
    total++;
    if (cap_line[17] !== 1'b1 || cap_busy[17] !== 1'b1) begin
      bad++; $display("FAIL pre_reset_bit3 ser=%b busy=%b want 1 1", cap_line[17], cap_busy[17]);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (ser8 !== 1'b1 || busy8 !== 1'b0 || if8.tx_ready !== 1'b1) begin
      bad++; $display("FAIL async_reset ser=%b busy=%b ready=%b want 1 0 1", ser8, busy8, if8.tx_ready);
    end
    repeat (2) @(negedge sys_clk);
    total++;
    if (ser8 !== 1'b1 || busy8 !== 1'b0) begin
      bad++; $display("FAIL held_reset ser=%b busy=%b want 1 0", ser8, busy8);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    total++;
    if (ser8 !== 1'b1 || busy8 !== 1'b0) begin
      bad++; $display("FAIL no_resume ser=%b busy=%b want 1 0", ser8, busy8);
    end
    send8(8'h3C, 1'b0, 1'b0, PARITY_EVEN);
    capture8(41);
    for (int i = 0; i < 40; i++) begin
      total++;
      if (cap_line[i] !== exp[i/4]) begin
        bad++; $display("FAIL post_reset_line cyc=%0d got=%b want=%b", i, cap_line[i], exp[i/4]);
      end
    end
    total++;
    if (cap_busy[39] !== 1'b1 || cap_busy[40] !== 1'b0) begin
      bad++; $display("FAIL post_reset_len busy39=%b busy40=%b want 1 0", cap_busy[39], cap_busy[40]);
    end
  endtask

  task automatic test_small_word;
    logic [6:0] exp;
    exp = 7'b1101010;  // 5'h15, CLK_DIV=2
    @(negedge sys_clk);
    if5.tx_valid = 1'b1;
    if5.tx_data  = 5'h15;
    if5.two_stop = 1'b0;
    @(posedge sys_clk);
    #1;
    if5.tx_valid = 1'b0;
    if5.tx_data  = 5'h0A;
    for (int i = 0; i < 15; i++) begin
      @(negedge sys_clk);
      cap_line[i]  = ser5;
      cap_busy[i]  = busy5;
      cap_ready[i] = if5.tx_ready;
    end
    for (int i = 0; i < 14; i++) begin
      total++;
      if (cap_line[i] !== exp[i/2] || cap_busy[i] !== 1'b1) begin
        bad++; $display("FAIL small_line cyc=%0d ser=%b busy=%b want ser=%b busy=1", i, cap_line[i], cap_busy[i], exp[i/2]);
      end
    end
    total++;
    if (cap_busy[14] !== 1'b0 || cap_ready[14] !== 1'b1 || cap_line[14] !== 1'b1) begin
      bad++; $display("FAIL small_end busy=%b ready=%b ser=%b want 0 1 1", cap_busy[14], cap_ready[14], cap_line[14]);
    end
  endtask

  initial begin
    if8.tx_valid = 1'b0;
    if8.tx_data  = '0;
    if8.two_stop = 1'b0;
    if5.tx_valid = 1'b0;
    if5.tx_data  = '0;
    if5.two_stop = 1'b0;
`ifdef UART_TX_PARITY_EN
    if8.parity_en = 1'b0;
    if8.even_odd  = 1'b0;
    if5.parity_en = 1'b0;
    if5.even_odd  = 1'b0;
`endif
    test_reset();
    test_basic();
    test_two_stop();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_reset_mid_frame();
    test_small_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
